// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and default bus widths.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single-cycle-latency memory.
// Define ARB_RR_EN for round-robin on contention; default is fixed d-over-if priority.
//
// state   | meaning
// IDLE    | no response due this cycle
// RESP_IF | fetch response due this cycle (data from mem_rdata)
// RESP_D  | load data / store acknowledge due this cycle
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e state_q, state_d;

`ifdef ARB_RR_EN
  // Set when fetch should win the next tie, i.e. the last grant went to d.
  logic rr_if_q, rr_if_d;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (d_req && (!if_req || !rr_if_q)) d_gnt = 1'b1;
      else if (if_req)                    if_gnt = 1'b1;
    end
    rr_if_d = rr_if_q;
    if (d_gnt)       rr_if_d = 1'b1;
    else if (if_gnt) rr_if_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_if_q <= 1'b0;
    else     rr_if_q <= rr_if_d;
  end
`else
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (d_req)       d_gnt  = 1'b1;
      else if (if_req) if_gnt = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = IDLE;
    if (d_gnt)       state_d = RESP_D;
    else if (if_gnt) state_d = RESP_IF;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_addr  = '0;
    mem_we    = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_we    = d_be;
        mem_wdata = d_wdata;
      end
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  // Masking with rst drops a response that was in flight when reset hit.
  assign if_rvalid = (state_q == RESP_IF) && !rst;
  assign d_rvalid  = (state_q == RESP_D) && !rst;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level model of who gets granted and who is owed a response. Honours ARB_RR_EN.
module tb_mem_arbiter;
  import cpu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [3:0]    d_be;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: who (0 none, 1 fetch, 2 data) gets the grant and who is owed a response.
  int m_resp = 0;
  bit started = 1'b0;
`ifdef ARB_RR_EN
  bit m_if_turn = 1'b0;
`endif

  function automatic int exp_gnt();
    if (rst) return 0;
    if (d_req && if_req) begin
`ifdef ARB_RR_EN
      return m_if_turn ? 1 : 2;
`else
      return 2;
`endif
    end
    if (d_req)  return 2;
    if (if_req) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    int g;
    g = exp_gnt();
    started = 1'b1;
    if (rst) begin
      m_resp = 0;
`ifdef ARB_RR_EN
      m_if_turn = 1'b0;
`endif
    end else begin
      m_resp = g;
`ifdef ARB_RR_EN
      if (g == 2)      m_if_turn = 1'b1;
      else if (g == 1) m_if_turn = 1'b0;
`endif
    end
  end

  always @(negedge clk) begin
    int g;
    bit rif, rd;
    if (started) begin
      g   = exp_gnt();
      rif = (m_resp == 1) && !rst;
      rd  = (m_resp == 2) && !rst;
      chk("m_if_gnt", 64'(if_gnt), 64'(g == 1));
      chk("m_d_gnt", 64'(d_gnt), 64'(g == 2));
      chk("m_mem_en", 64'(mem_en), 64'(g != 0));
      chk("m_mem_we", 64'(mem_we), (g == 2 && d_we) ? 64'(d_be) : 64'd0);
      if (g == 2) chk("m_mem_addr", 64'(mem_addr), 64'(d_addr));
      if (g == 1) chk("m_mem_addr", 64'(mem_addr), 64'(if_addr));
      if (g == 2 && d_we) chk("m_mem_wdata", 64'(mem_wdata), 64'(d_wdata));
      chk("m_if_rvalid", 64'(if_rvalid), 64'(rif));
      chk("m_d_rvalid", 64'(d_rvalid), 64'(rd));
      chk("m_if_rdata", 64'(if_rdata), rif ? 64'(mem_rdata) : 64'd0);
      chk("m_d_rdata", 64'(d_rdata), rd ? 64'(mem_rdata) : 64'd0);
    end
  end

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit exp_d [4];
`ifdef ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = 32'h1234_5678;

    // Reset held with both requests high: everything quiet.
    repeat (5) begin
      @(negedge clk);
      chk("rst_gnt", 64'({if_gnt, d_gnt}), 64'd0);
      chk("rst_mem", 64'({mem_en, mem_we}), 64'd0);
      chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
      chk("rst_rdata", 64'(if_rdata | d_rdata), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first_gnt_d", 64'(d_gnt), 64'd1);
    chk("first_gnt_if", 64'(if_gnt), 64'd0);

    // Store.
    nx();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000;
    d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    @(negedge clk);
    chk("st_gnt", 64'(d_gnt), 64'd1);
    chk("st_mem_we", 64'(mem_we), 64'h3);
    chk("st_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("st_mem_addr", 64'(mem_addr), 64'h2000);

    // Fetch, overlapping the store acknowledge.
    nx();
    d_req = 1'b0; d_we = 1'b0; d_be = '0; if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("st_rvalid", 64'(d_rvalid), 64'd1);
    chk("if_gnt", 64'(if_gnt), 64'd1);
    chk("if_mem_addr", 64'(mem_addr), 64'h100);
    chk("if_mem_we", 64'(mem_we), 64'd0);
    nx();
    if_req = 1'b0; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    chk("if_rvalid", 64'(if_rvalid), 64'd1);
    chk("if_rdata", 64'(if_rdata), 64'h0050_0093);
    chk("if_mem_en_idle", 64'(mem_en), 64'd0);

    // Contention for 4 cycles; the last grant before this was to fetch.
    for (int k = 0; k < 4; k++) begin
      nx();
      if_req = 1'b1; d_req = 1'b1; if_addr = 32'h40 + 32'(k); d_addr = 32'h3000 + 32'(k);
      @(negedge clk);
      chk("con_d_gnt", 64'(d_gnt), 64'(exp_d[k]));
      chk("con_if_gnt", 64'(if_gnt), 64'(!exp_d[k]));
      if (k > 0) begin
        chk("con_d_rvalid", 64'(d_rvalid), 64'(exp_d[k-1]));
        chk("con_if_rvalid", 64'(if_rvalid), 64'(!exp_d[k-1]));
      end
    end
    nx();
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("con_d_rvalid_last", 64'(d_rvalid), 64'(exp_d[3]));
    chk("con_if_rvalid_last", 64'(if_rvalid), 64'(!exp_d[3]));

    // Reset lands while a load response is in flight.
    nx();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    @(negedge clk);
    chk("mid_gnt", 64'(d_gnt), 64'd1);
    nx();
    d_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rvalid_rst", 64'(d_rvalid), 64'd0);
    nx();
    rst = 1'b0;
    chk("mid_state_idle", 64'(dut.state_q), 64'(IDLE));
    @(negedge clk);
    chk("mid_rvalid_after", 64'(d_rvalid), 64'd0);

    // Randomized traffic, with the occasional reset.
    repeat (3000) begin
      nx();
      rst       = ($urandom_range(0, 63) == 0);
      if_req    = 1'($urandom);
      d_req     = 1'($urandom);
      d_we      = 1'($urandom);
      if_addr   = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_be      = 4'($urandom);
      mem_rdata = $urandom;
    end
    nx();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    nx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
